// File: rtl/comp_arb_pkg.sv
// Shared types and constants for the comparator arbiter slice.
package comp_arb_pkg;

  localparam int OPERAND_W = 4;
  localparam int MAX_REQ   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/comparator_4_bits.sv
// Unsigned 4-bit magnitude comparator; exactly one output is high.
module comparator_4_bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       equal,
  output logic       less,
  output logic       higher
);

  assign equal  = (a == b);
  assign less   = (a < b);
  assign higher = (a > b);

endmodule

// File: rtl/comparator_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester found scanning from
// ptr upward (wrapping) wins. With ptr tied to zero it is a fixed-priority
// arbiter where the lowest index wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  winner,
  output logic             any_grant
);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [ID_W-1:0]    offset;
  logic [ID_W:0]      sum;

  // Rotate requests so bit 0 is the pointer position, take the lowest set
  // bit, then rotate the result back into an absolute index.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    offset    = '0;
    any_grant = 1'b0;
    doubled   = {req, req} >> ptr;
    rotated   = doubled[N_REQ-1:0];
    // Descending scan: the last hit written is the lowest offset.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        offset    = ID_W'(k);
        any_grant = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (ID_W+1)'(N_REQ)) begin
      sum = sum - (ID_W+1)'(N_REQ);
    end
    winner = sum[ID_W-1:0];
    grant  = any_grant ? (N_REQ'(1) << winner) : '0;
  end

endmodule

// File: rtl/comparator_arbiter.sv
// Shares one comparator_4_bits among N_REQ requesters. A grant in IDLE
// captures the winner's operands, COMPARE registers the result, RESPOND holds
// it until the consumer accepts. One comparison is in flight at a time.
// Build option: define COMP_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins); the default build is round-robin.
module comparator_arbiter
  import comp_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [OPERAND_W*N_REQ-1:0] req_a,
  input  logic [OPERAND_W*N_REQ-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       rsp_equal,
  output logic                       rsp_less,
  output logic                       rsp_higher
);

  state_t                 state, next_state;
  logic [ID_W-1:0]        ptr;
  logic [ID_W-1:0]        winner;
  logic [N_REQ-1:0]       grant;
  logic                   any_grant;
  logic                   take;
  logic [OPERAND_W-1:0]   sel_a, sel_b;
  logic [OPERAND_W-1:0]   op_a, op_b;
  logic [ID_W-1:0]        op_id;
  logic                   cmp_equal, cmp_less, cmp_higher;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  comparator_4_bits u_cmp (
    .a      (op_a),
    .b      (op_b),
    .equal  (cmp_equal),
    .less   (cmp_less),
    .higher (cmp_higher)
  );

  // Grants are only visible while idle; the handshake completes that cycle.
  assign req_ready = (state == IDLE) ? grant : '0;
  assign take      = (state == IDLE) && any_grant;

  // Pick the winner's operand slices.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_a = req_a[i*OPERAND_W +: OPERAND_W];
        sel_b = req_b[i*OPERAND_W +: OPERAND_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_grant) next_state = COMPARE;
      COMPARE: next_state = RESPOND;
      RESPOND: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture the granted request; later operand changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      op_id <= '0;
    end else if (take) begin
      op_a  <= sel_a;
      op_b  <= sel_b;
      op_id <= winner;
    end
  end

  // Response registers: loaded in COMPARE, held until accepted in RESPOND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_equal  <= 1'b0;
      rsp_less   <= 1'b0;
      rsp_higher <= 1'b0;
    end else if (state == COMPARE) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= op_id;
      rsp_equal  <= cmp_equal;
      rsp_less   <= cmp_less;
      rsp_higher <= cmp_higher;
    end else if (state == RESPOND && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef COMP_ARB_FIXED_PRIO_EN
  // Fixed priority: scanning always starts at requester 0.
  assign ptr = '0;
`else
  // Round-robin pointer: the requester after the last winner goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed bench for comparator_arbiter (N_REQ=4). Expected responses are
// queued at stimulus time; a monitor pops and compares on each accepted
// response.
module tb_comparator_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam logic [2:0] EQ = 3'b100;  // {equal, less, higher}
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_REQ-1:0] req_valid, req_ready;
  logic [4*N_REQ-1:0] req_a, req_b;
  logic             rsp_valid, rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  logic             rsp_equal, rsp_less, rsp_higher;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [2:0]      flags;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Per-requester operands used by the held-request tests.
  logic [3:0] tbl_a [N_REQ] = '{4'd1, 4'd5, 4'd9, 4'd0};
  logic [3:0] tbl_b [N_REQ] = '{4'd2, 4'd5, 4'd3, 4'd15};
  logic [2:0] tbl_f [N_REQ] = '{LT, EQ, GT, LT};

  comparator_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_equal  (rsp_equal),
    .rsp_less   (rsp_less),
    .rsp_higher (rsp_higher)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one-hot invariant while valid, scoreboard compare on accept.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      check("rsp_onehot", $countones({rsp_equal, rsp_less, rsp_higher}), 1);
      if (rsp_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got id=%0d with empty scoreboard", rsp_id);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_id", rsp_id, mon_e.id);
          check("rsp_flags", {rsp_equal, rsp_less, rsp_higher}, mon_e.flags);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int id, input logic [2:0] f);
    exp_t t;
    t.id    = ID_W'(id);
    t.flags = f;
    sb.push_back(t);
  endtask

  task automatic set_op(input int id, input logic [3:0] a, input logic [3:0] b);
    req_a[id*4 +: 4] = a;
    req_b[id*4 +: 4] = b;
  endtask

  // Waits (bounded) for any grant at a falling edge and checks which one.
  task automatic wait_grant(input logic [N_REQ-1:0] exp_mask, output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 30);
    check("grant", req_ready, exp_mask);
    at = cyc;
  endtask

  // Single request; returns at the falling edge of the COMPARE cycle.
  task automatic request(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] f);
    int at;
    set_op(id, a, b);
    req_valid[id] = 1'b1;
    push_exp(id, f);
    wait_grant(N_REQ'(1) << id, at);
    tick();
    req_valid[id] = 1'b0;
    @(negedge clk);
    check("grant_pulse", req_ready, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    tick();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_flags"}, {rsp_equal, rsp_less, rsp_higher}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("rst");
    tick();
    rst_n = 1'b1;
  endtask

  // Requesters in mask held valid; grants must follow ids[0..n-1], 3 cycles apart.
  task automatic held(input logic [N_REQ-1:0] mask, input int ids[5], input int n);
    int at, prev;
    prev = 0;
    for (int i = 0; i < N_REQ; i++) set_op(i, tbl_a[i], tbl_b[i]);
    for (int i = 0; i < n; i++) push_exp(ids[i], tbl_f[ids[i]]);
    req_valid = mask;
    for (int i = 0; i < n; i++) begin
      wait_grant(N_REQ'(1) << ids[i], at);
      if (i > 0) check("grant_spacing", at - prev, 3);
      prev = at;
    end
    tick();
    req_valid = '0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int at;
    int n;
    int rr_ids[5];
    int pair_ids[5];
`ifdef COMP_ARB_FIXED_PRIO_EN
    rr_ids   = '{0, 0, 0, 0, 0};
    pair_ids = '{1, 1, 1, 0, 0};
`else
    rr_ids   = '{0, 1, 2, 3, 0};
    pair_ids = '{1, 3, 1, 0, 0};
`endif
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("init");
    rst_n = 1'b1;
    tick();

    // Single request: 5 vs 0 is HIGHER; response two edges after the grant.
    request(0, 4'b0101, 4'b0000, GT);
    check("latency_early", rsp_valid, 0);
    @(negedge clk);
    check("latency_valid", rsp_valid, 1);
    drain();

    // Equal then less from requester 2.
    request(2, 4'b0011, 4'b0011, EQ);
    drain();
    request(2, 4'b1000, 4'b1111, LT);
    drain();

    // Round-robin with all four held, starting from a fresh pointer.
    do_reset();
    held(4'hF, rr_ids, 5);

    // Backpressure: response held, no grants, then grant one cycle after release.
    rsp_ready = 1'b0;
    request(1, 4'b1010, 4'b1011, LT);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    check("bp_valid", rsp_valid, 1);
    set_op(3, 4'd7, 4'd7);
    req_valid[3] = 1'b1;
    push_exp(3, EQ);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_id", rsp_id, 1);
      check("bp_hold_flags", {rsp_equal, rsp_less, rsp_higher}, LT);
      check("bp_no_grant", req_ready, 0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_valid", rsp_valid, 0);
    check("bp_next_grant", req_ready, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    drain();

    // Async reset in RESPOND: outputs clear at once, pointer returns to 0.
    rsp_ready = 1'b0;
    request(1, 4'd6, 4'd2, GT);
    @(negedge clk);
    check("pre_rst_valid", rsp_valid, 1);
    do_reset();
    sb.delete();
    rsp_ready = 1'b1;
    set_op(0, 4'd4, 4'd2);
    set_op(3, 4'd4, 4'd6);
    push_exp(0, GT);
    req_valid = 4'b1001;
    wait_grant(4'b0001, at);
    tick();
    req_valid = '0;
    drain();

    // Requesters 1 and 3 held.
    held(4'b1010, pair_ids, 3);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator_arbiter.md
Name: comparator_arbiter

Overview:
- Shares one comparator_4_bits instance among N_REQ requesters via a round-robin arbiter.
- Each requester presents an A/B operand pair with a valid/ready handshake.
- The block returns EQUAL/LESS/HIGHER tagged with the requester index on a single valid/ready response channel.
- Sits between the requester ports and the shared comparator datapath; one comparison is in flight at a time.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of the requester index.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- REQ_VALID  in  N_REQ  per-requester request valid.
- REQ_READY  out  N_REQ  per-requester grant/accept, at most one bit high.
- REQ_A  in  4*N_REQ  operand A, requester i at bits [4i+3:4i].
- REQ_B  in  4*N_REQ  operand B, same packing.
- RSP_VALID  out  1  result valid.
- RSP_READY  in  1  consumer accepts result.
- RSP_ID  out  ID_W  index of the requester that owns the result.
- RSP_EQUAL  out  1  A == B.
- RSP_LESS  out  1  A < B, unsigned.
- RSP_HIGHER  out  1  A > B, unsigned.

Behaviour:
- Reset (asynchronous, immediate on RST_N low):
  - state=IDLE, REQ_READY=0, RSP_VALID=0, RSP_ID=0, all flags 0, priority pointer=0.
  - Reset mid-operation abandons the captured request and any pending response; nothing is replayed.
- FSM states: IDLE, COMPARE, RESPOND.
- IDLE:
  - winner = first i with REQ_VALID[i]=1, scanning pointer, pointer+1, … modulo N_REQ.
  - REQ_READY[winner] is driven high combinationally in IDLE only. The handshake completes in that cycle.
  - At the clock edge: capture REQ_A/REQ_B slices and the winner index into operand registers; pointer <= (winner+1) mod N_REQ; go to COMPARE.
  - If no REQ_VALID is high: REQ_READY=0, stay in IDLE, pointer unchanged.
- COMPARE:
  - Registered operands drive comparator_4_bits.
  - Its EQUAL/LESS/HIGHER outputs and the captured index are registered into the RSP_* outputs.
  - RSP_VALID <= 1; go to RESPOND. REQ_READY=0.
- RESPOND:
  - All RSP_* outputs are held stable while RSP_VALID=1 and RSP_READY=0.
  - On RSP_READY=1: RSP_VALID <= 0, go to IDLE.
  - No new grant is issued in the same cycle; REQ_READY=0 throughout RESPOND.
- Latency: grant at edge k, RSP_VALID high after edge k+1. Minimum 3 cycles per transaction.
- Requester rules:
  - A requester must hold REQ_VALID and operands stable until REQ_READY.
  - Deasserting REQ_VALID before grant withdraws the request legally.
  - Operand changes after grant are ignored.
- Invariant: while RSP_VALID=1, exactly one of RSP_EQUAL/RSP_LESS/RSP_HIGHER is 1.
- Fairness: a continuously requesting requester is granted within N_REQ transactions.
- A REQ_VALID asserted during COMPARE or RESPOND simply waits for IDLE.

Optional Feature:
- Macro: COMP_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The pointer register is not implemented and behaves as constant 0.
- Undefined (default): round-robin as above.
- Handshake, latency and reset behaviour are identical in both modes.

Decomposition:
- Package comp_arb_pkg holds:
  - state enum {IDLE, COMPARE, RESPOND}, 2 bits;
  - localparam OPERAND_W=4;
  - localparam MAX_REQ=8.
- One sub-module, rr_arbiter:
  - inputs: request vector, pointer;
  - outputs: one-hot grant, winner index, any_grant;
  - combinational.
- The top holds the FSM, operand/result registers, pointer, and the comparator_4_bits instance.

Test Plan:
- Reset then single request: REQ_VALID=0001, A=0101, B=0000, RSP_READY=1.
  - REQ_READY=0001 for one cycle.
  - 2 cycles later RSP_VALID=1, RSP_ID=0, HIGHER=1, LESS=0, EQUAL=0.
- Equal and less: requester 2 sends A=0011/B=0011, then A=1000/B=1111.
  - EQUAL=1 for the first; LESS=1 for the second; RSP_ID=2 both.
- Round-robin: all four REQ_VALID held high, RSP_READY=1.
  - Grant order 0,1,2,3,0; each grant spaced 3 cycles apart.
- Backpressure: RSP_READY=0 for 5 cycles after RSP_VALID, with A=1010/B=1011.
  - RSP_* stable, LESS=1, no REQ_READY pulses.
  - Release RSP_READY: RSP_VALID drops next edge; next grant one cycle later.
- Async reset mid-RESPOND: assert RST_N=0 between edges.
  - RSP_VALID, flags and REQ_READY go 0 immediately; pointer returns to 0.
  - After release, the first grant goes to requester 0 when requesters 0 and 3 both request.
- With COMP_ARB_FIXED_PRIO_EN: requesters 1 and 3 held valid.
  - Requester 1 granted every transaction; 3 never granted while 1 is valid.
